// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared screen geometry, ball centre and ball state encoding for the pong display path
package pong_pkg;

  localparam int H_VIS     = 640;
  localparam int V_VIS     = 480;
  localparam int BALL_SIZE = 8;

  // Serve position; pixel_gen draws from the same values.
  localparam int BALL_X_C = (H_VIS - BALL_SIZE) / 2;
  localparam int BALL_Y_C = (V_VIS - BALL_SIZE) / 2;

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    MISS
  } ball_state_t;

endpackage

// File: rtl/bcd_counter2.sv
// rtl/bcd_counter2.sv - two-digit BCD counter, 99 wraps to 00, clear beats increment
module bcd_counter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (inc) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ball_ctrl.sv
// rtl/ball_ctrl.sv - per-frame ball motion, edge/wall/paddle reflection, miss detection and return count
module ball_ctrl #(
  parameter int H_VIS       = pong_pkg::H_VIS,
  parameter int V_VIS       = pong_pkg::V_VIS,
  parameter int BALL_SIZE   = pong_pkg::BALL_SIZE,
  parameter int BALL_V      = 2,
  parameter int WALL_X_R    = 39,
  parameter int PAD_X_L     = 600,
  parameter int PAD_X_R     = 603,
  parameter int PAD_H       = 72,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       serve,
  input  logic [9:0] pad_y_t,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       playing,
  output logic       miss,
  output logic [3:0] hits_ones,
  output logic [3:0] hits_tens
);

  typedef logic signed [10:0] s11_t;

  localparam logic [9:0] CX = 10'((H_VIS - BALL_SIZE) / 2);
  localparam logic [9:0] CY = 10'((V_VIS - BALL_SIZE) / 2);
  localparam int         CW = $clog2(MISS_FRAMES + 1);
  localparam s11_t       VS = s11_t'(BALL_V);

  pong_pkg::ball_state_t state, state_nx;
  logic [9:0]    x_q, y_q, x_nx, y_nx;
  logic          dx_neg, dy_neg, dx_neg_nx, dy_neg_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          miss_nx, hit_inc, hit_clr;

  s11_t xs, ys, pad_t, right_e, bot_e;
  logic top_hit, bot_hit, wall_hit, pad_hit, miss_hit;

  // Collision tests in 11-bit signed so position +/- offsets never wrap.
  always_comb begin
    xs       = s11_t'({1'b0, x_q});
    ys       = s11_t'({1'b0, y_q});
    pad_t    = s11_t'({1'b0, pad_y_t});
    right_e  = xs + s11_t'(BALL_SIZE - 1);
    bot_e    = ys + s11_t'(BALL_SIZE - 1);
    top_hit  = ys < VS;
    bot_hit  = bot_e > s11_t'(V_VIS - 1 - BALL_V);
    wall_hit = xs <= s11_t'(WALL_X_R + BALL_V);
    pad_hit  = (right_e >= s11_t'(PAD_X_L)) && (right_e <= s11_t'(PAD_X_R)) &&
               (bot_e >= pad_t) && (ys <= pad_t + s11_t'(PAD_H - 1)) && !dx_neg;
    miss_hit = xs >= s11_t'(H_VIS - BALL_SIZE);
  end

  always_comb begin
    state_nx  = state;
    x_nx      = x_q;
    y_nx      = y_q;
    dx_neg_nx = dx_neg;
    dy_neg_nx = dy_neg;
    cnt_nx    = cnt;
    miss_nx   = 1'b0;
    hit_inc   = 1'b0;
    hit_clr   = 1'b0;
    case (state)
      pong_pkg::SERVE: begin
        if (serve) state_nx = pong_pkg::PLAY;
      end
      pong_pkg::PLAY: begin
        if (refresh_tick) begin
          if (miss_hit) begin
            state_nx = pong_pkg::MISS;
            miss_nx  = 1'b1;
            hit_clr  = 1'b1;
          end else begin
            if (pad_hit) begin
              dx_neg_nx = 1'b1;
              hit_inc   = 1'b1;
            end else if (wall_hit) begin
              dx_neg_nx = 1'b0;
            end
            if (top_hit)      dy_neg_nx = 1'b0;
            else if (bot_hit) dy_neg_nx = 1'b1;
            x_nx = dx_neg_nx ? x_q - 10'(BALL_V) : x_q + 10'(BALL_V);
            y_nx = dy_neg_nx ? y_q - 10'(BALL_V) : y_q + 10'(BALL_V);
          end
        end
      end
      pong_pkg::MISS: begin
        if (refresh_tick) begin
          if (cnt == CW'(MISS_FRAMES - 1)) begin
            state_nx  = pong_pkg::SERVE;
            x_nx      = CX;
            y_nx      = CY;
            dx_neg_nx = 1'b0;
            dy_neg_nx = 1'b0;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: state_nx = pong_pkg::SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= pong_pkg::SERVE;
      x_q     <= CX;
      y_q     <= CY;
      dx_neg  <= 1'b0;
      dy_neg  <= 1'b0;
      cnt     <= '0;
      miss    <= 1'b0;
      playing <= 1'b0;
    end else begin
      state   <= state_nx;
      x_q     <= x_nx;
      y_q     <= y_nx;
      dx_neg  <= dx_neg_nx;
      dy_neg  <= dy_neg_nx;
      cnt     <= cnt_nx;
      miss    <= miss_nx;
      playing <= (state_nx == pong_pkg::PLAY);
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;

  bcd_counter2 u_hits (
    .clk   (clk),
    .reset (reset),
    .clr   (hit_clr),
    .inc   (hit_inc),
    .ones  (hits_ones),
    .tens  (hits_tens)
  );

endmodule

// File: tb/tb_ball_ctrl.sv
// tb/tb_ball_ctrl.sv - scoreboard bench for ball_ctrl: full-size field plus a short field for the return counter
module tb_ball_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       tick_a = 1'b0, serve_a = 1'b0, tick_b = 1'b0, serve_b = 1'b0;
  logic [9:0] pad_a = 10'd400, pad_b = 10'd0;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       pl_a, ms_a, pl_b, ms_b;
  logic [3:0] one_a, ten_a, one_b, ten_b;

  ball_ctrl dut_a (
    .clk(clk), .reset(reset), .refresh_tick(tick_a), .serve(serve_a), .pad_y_t(pad_a),
    .ball_x(x_a), .ball_y(y_a), .playing(pl_a), .miss(ms_a),
    .hits_ones(one_a), .hits_tens(ten_a)
  );

  ball_ctrl #(.H_VIS(160), .PAD_X_L(100), .PAD_X_R(103), .PAD_H(512)) dut_b (
    .clk(clk), .reset(reset), .refresh_tick(tick_b), .serve(serve_b), .pad_y_t(pad_b),
    .ball_x(x_b), .ball_y(y_b), .playing(pl_b), .miss(ms_b),
    .hits_ones(one_b), .hits_tens(ten_b)
  );

  // Mask bits: 0 ball_x, 1 ball_y, 2 playing, 3 miss, 4 hits
  typedef struct {
    int         id;
    logic [4:0] m;
    int         x, y, pl, ms, h;
    string      tag;
  } exp_t;

  localparam logic [4:0] ALL = 5'h1F;

  exp_t sb[$];
  exp_t me;
  int   n_chk = 0, n_fail = 0;
  int   ax, ay, apl, ams, ah;
  logic ta_q = 1'b0, tb_q = 1'b0, pr_q = 1'b0, probe = 1'b0;

  task automatic cmp(input string tag, input string f, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, f, act, exp);
    end
  endtask

  always @(posedge clk) begin
    ta_q <= tick_a;
    tb_q <= tick_b;
    pr_q <= probe;
  end

  // Monitor: one scoreboard entry per registered tick or probe cycle.
  always @(negedge clk) begin
    if (ta_q || tb_q || pr_q) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got output with no expectation queued");
      end else begin
        me = sb.pop_front();
        if (me.id == 0) begin
          ax = int'(x_a); ay = int'(y_a); apl = int'(pl_a); ams = int'(ms_a); ah = int'({ten_a, one_a});
        end else begin
          ax = int'(x_b); ay = int'(y_b); apl = int'(pl_b); ams = int'(ms_b); ah = int'({ten_b, one_b});
        end
        if (me.m[0]) cmp(me.tag, "ball_x", ax, me.x);
        if (me.m[1]) cmp(me.tag, "ball_y", ay, me.y);
        if (me.m[2]) cmp(me.tag, "playing", apl, me.pl);
        if (me.m[3]) cmp(me.tag, "miss", ams, me.ms);
        if (me.m[4]) cmp(me.tag, "hits", ah, me.h);
      end
    end
  end

  task automatic push(input int id, input logic [4:0] m, input int x, input int y,
                      input int pl, input int ms, input int h, input string tag);
    exp_t e;
    e.id = id; e.m = m; e.x = x; e.y = y; e.pl = pl; e.ms = ms; e.h = h; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input int id);
    @(posedge clk); #1;
    if (id == 0) tick_a = 1'b1; else tick_b = 1'b1;
    @(posedge clk); #1;
    tick_a = 1'b0;
    tick_b = 1'b0;
  endtask

  // Tick followed immediately by a probe of the very next cycle.
  task automatic tick_probe();
    @(posedge clk); #1 tick_a = 1'b1;
    @(posedge clk); #1 tick_a = 1'b0; probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
  endtask

  task automatic probe_now();
    @(posedge clk); #1 probe = 1'b1;
    @(posedge clk); #1 probe = 1'b0;
  endtask

  task automatic run(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      push(id, 5'h00, 0, 0, 0, 0, 0, "run");
      tick(id);
    end
  endtask

  task automatic serve_pulse(input int id);
    @(posedge clk); #1;
    if (id == 0) serve_a = 1'b1; else serve_b = 1'b1;
    @(posedge clk); #1;
    serve_a = 1'b0;
    serve_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    push(0, ALL, 316, 236, 0, 0, 'h00, "reset_a");
    probe_now();
    push(1, ALL, 76, 236, 0, 0, 'h00, "reset_b");
    probe_now();

    for (int i = 0; i < 10; i++) begin
      push(0, ALL, 316, 236, 0, 0, 'h00, "serve_idle");
      tick(0);
    end

    serve_pulse(0);
    push(0, ALL, 316, 236, 1, 0, 'h00, "serve_to_play");
    probe_now();
    push(0, ALL, 318, 238, 1, 0, 'h00, "first_move");
    tick(0);
    run(0, 116);
    push(0, ALL, 552, 472, 1, 0, 'h00, "bottom_max");
    tick(0);
    push(0, ALL, 554, 470, 1, 0, 'h00, "bottom_reflect");
    tick(0);
    run(0, 1);
    push(0, ALL, 558, 466, 1, 0, 'h00, "after_120");
    tick(0);
    run(0, 18);
    push(0, ALL, 592, 428, 1, 0, 'h01, "paddle_return");
    tick(0);
    run(0, 275);
    push(0, ALL, 40, 124, 1, 0, 'h01, "wall_min");
    tick(0);
    push(0, ALL, 42, 126, 1, 0, 'h01, "wall_reflect");
    tick(0);
    pad_a = 10'd0;
    run(0, 294);
    push(0, ALL, 632, 228, 1, 0, 'h01, "pre_miss");
    tick(0);
    push(0, ALL, 632, 228, 0, 1, 'h00, "miss_pulse");
    push(0, ALL, 632, 228, 0, 0, 'h00, "miss_one_cycle");
    tick_probe();

    serve_a = 1'b1;
    for (int i = 0; i < 59; i++) begin
      push(0, ALL, 632, 228, 0, 0, 'h00, "miss_hold");
      tick(0);
    end
    serve_a = 1'b0;
    push(0, ALL, 316, 236, 0, 0, 'h00, "miss_recentre");
    tick(0);

    @(posedge clk); #1 serve_a = 1'b1; tick_a = 1'b1;
    push(0, ALL, 316, 236, 1, 0, 'h00, "serve_tick_same");
    @(posedge clk); #1 serve_a = 1'b0; tick_a = 1'b0;
    push(0, ALL, 318, 238, 1, 0, 'h00, "post_serve_move");
    tick(0);
    run(0, 157);
    push(0, ALL, 632, 392, 0, 1, 'h00, "miss_again");
    tick(0);
    run(0, 5);
    push(0, ALL, 316, 236, 0, 0, 'h00, "reset_in_miss");
    @(posedge clk); #1 reset = 1'b1; tick_a = 1'b1;
    @(posedge clk); #1 reset = 1'b0; tick_a = 1'b0;
    push(0, ALL, 316, 236, 0, 0, 'h00, "reset_settled");
    probe_now();

    serve_pulse(1);
    run(1, 9);
    push(1, 5'h15, 92, 0, 1, 0, 'h01, "short_first_return");
    tick(1);
    run(1, 484);
    push(1, 5'h10, 0, 0, 0, 0, 'h09, "hits_nine");
    tick(1);
    push(1, 5'h15, 92, 0, 1, 0, 'h10, "hits_carry");
    tick(1);
    run(1, 4805);
    push(1, 5'h15, 92, 0, 1, 0, 'h99, "hits_99");
    tick(1);
    run(1, 53);
    push(1, 5'h15, 92, 0, 1, 0, 'h00, "hits_wrap");
    tick(1);

    repeat (4) @(posedge clk);
    cmp("scoreboard", "pending", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_ctrl.md
# ball_ctrl

Frame-rate ball engine for the pong display path. Sits directly upstream of `pixel_gen`, which consumes its outputs. Each frame it advances a square ball's position, reflects it off the top and bottom edges, the left wall and the right paddle, and detects misses. It also keeps a two-digit BCD count of paddle returns and runs a serve / play / miss-hold state machine.

## Interface
Parameters:
- `H_VIS`, 640, visible width in pixels
- `V_VIS`, 480, visible height in pixels
- `BALL_SIZE`, 8, ball edge length in pixels
- `BALL_V`, 2, pixels moved per frame on each axis; must be ≤ `PAD_X_R-PAD_X_L+1`
- `WALL_X_R`, 39, rightmost column of the left wall
- `PAD_X_L`, 600, paddle left column
- `PAD_X_R`, 603, paddle right column
- `PAD_H`, 72, paddle height
- `MISS_FRAMES`, 60, frames held in MISS

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `refresh_tick` in 1: one-cycle pulse, once per frame
- `serve` in 1: debounced serve request (level)
- `pad_y_t` in 10: paddle top row
- `ball_x` out 10: ball left column
- `ball_y` out 10: ball top row
- `playing` out 1: high in PLAY
- `miss` out 1: one-cycle pulse on miss
- `hits_ones` out 4: BCD low digit of returns
- `hits_tens` out 4: BCD high digit of returns

## Operation
- Reset (dominates all inputs): state SERVE, `ball_x`=316 ((H_VIS-BALL_SIZE)/2), `ball_y`=236, dx=+BALL_V, dy=+BALL_V, hits=00, `miss`=0, frame counter=0.
- SERVE: ball held at centre. When `serve`=1 on any clock, go to PLAY on the next edge. Motion starts at the first `refresh_tick` after that edge.
- PLAY: on each `refresh_tick`, compute the new direction from the current position, then move by the new direction. Checks:
  - top: `ball_y` < BALL_V → dy=+V.
  - bottom: `ball_y`+BALL_SIZE-1 > V_VIS-1-BALL_V → dy=-V.
  - left wall: `ball_x` ≤ WALL_X_R+BALL_V → dx=+V.
  - paddle: all of the following hold → dx=-V and hits increment by 1:
    - right edge (`ball_x`+BALL_SIZE-1) is within [PAD_X_L, PAD_X_R];
    - rows overlap (`ball_y`+BALL_SIZE-1 ≥ `pad_y_t` and `ball_y` ≤ `pad_y_t`+PAD_H-1);
    - dx is positive.
  - miss: `ball_x` ≥ H_VIS-BALL_SIZE → go to MISS, pulse `miss`, clear hits to 00, no move this tick.
- Precedence per tick: miss > paddle > wall. X and Y checks are independent, so a corner hit flips both axes in the same tick.
- MISS: ball frozen in place. Frame counter increments on each `refresh_tick`. When the count reaches MISS_FRAMES, go to SERVE, recentre the ball, restore reset directions, and clear the counter. `serve` is ignored in MISS.
- Hits: BCD, 99 → 00 wrap; ones 9 → 0 carries into tens.
- Arithmetic: 11-bit signed intermediates for position±V, so the comparisons never wrap.

## Timing
- All outputs are registered.
- Position, hits and `miss` update on the clock edge that samples `refresh_tick`=1, i.e. they are valid one cycle after the tick.
- `refresh_tick` outside PLAY/MISS has no effect. Ticks while in SERVE do nothing.
- `serve` and `refresh_tick` in the same SERVE cycle: transition to PLAY only; no move.
- `pad_y_t` is sampled only on tick cycles.
- Reset mid-PLAY or mid-MISS: full reset values on the next edge. `miss` is never asserted from reset.

## Structure
- Package `pong_pkg`:
  - screen constants `H_VIS`, `V_VIS`;
  - state enum `ball_state_t` {SERVE, PLAY, MISS};
  - centre-position localparams, shared with `pixel_gen` for drawing.
- Sub-module `bcd_counter2`: two-digit BCD counter with `clk`, `reset`, `clr`, `inc`, `ones`, `tens`; wraps 99→00; `clr` beats `inc`.

## Test plan
- Reset, then 10 ticks with `serve`=0 → `ball_x`=316, `ball_y`=236, `playing`=0, hits=00.
- Pulse `serve`, then 1 tick → `ball_x`=318, `ball_y`=238. After a further 120 ticks → `ball_y` has reflected off the bottom (never exceeds 472), dy negative.
- Hold `pad_y_t` level with the ball and run until it hits the paddle → dx flips on the tick where the right edge is in 600..603, hits=01; the ball then reflects off the left wall with `ball_x` ≥ 40.
- Move `pad_y_t` to 0 with the ball at `ball_y` ≥ 200 heading right → `miss` high for exactly 1 cycle when `ball_x` ≥ 632, hits=00, `playing`=0. After 60 ticks → SERVE, centre restored.
- Force 99 returns (short-distance parameter set) → hits roll to 00 on the 100th return. Assert `reset` during MISS → SERVE and centre on the next edge.
- `serve` and `refresh_tick` high in the same SERVE cycle → PLAY, position unchanged until the next tick.
